fetch_unit: RTL and testbench



---
 rtl/core_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit_pc_next_sel.sv | 39 +++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core constants and types used by the fetch stage.
package core_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP              = 32'd4;
   localparam logic [XLEN-1:0] ALIGN_MASK           = 32'hFFFF_FFFC;
   localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR    = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

   typedef enum logic [1:0] {
      PC_HOLD,
      PC_SEQ,
      PC_REDIRECT,
      PC_TRAP
   } pc_src_e;

   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return |(addr & ~ALIGN_MASK);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory port plus the IF/ID valid/ready handshake to decode.
interface fetch_unit_if;
   import core_pkg::*;

   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_pc_plus4;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output if_valid,
      input  if_ready,
      output if_instr,
      output if_pc,
      output if_pc_plus4
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  if_valid,
      output if_ready,
      input  if_instr,
      input  if_pc,
      input  if_pc_plus4
   );

endinterface

// File: rtl/fetch_unit_pc_next_sel.sv
// Combinational next-PC mux: redirect / trap / sequential +4 / hold, with target alignment.
module pc_next_sel
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR,
   parameter bit              TRAP_EN     = 1'b0
) (
   input  logic [XLEN-1:0] pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            advance,
   output logic [XLEN-1:0] pc_next
);

   pc_src_e src;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      src = PC_HOLD;
      if (redirect_valid) begin
         src = (TRAP_EN && is_misaligned(redirect_target)) ? PC_TRAP : PC_REDIRECT;
      end else if (advance) begin
         src = PC_SEQ;
      end
   end

   // The +4 add wraps naturally at 32 bits: 32'hFFFF_FFFC -> 0.
   always_comb begin
      pc_next = pc;
      unique case (src)
         PC_HOLD:     pc_next = pc;
         PC_SEQ:      pc_next = pc + PC_STEP;
         PC_REDIRECT: pc_next = redirect_target & ALIGN_MASK;
         PC_TRAP:     pc_next = TRAP_VECTOR;
         default:     pc_next = pc;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, IF/ID register and handshake counter.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
   parameter logic [XLEN-1:0] NOP_INSTR    = DEFAULT_NOP_INSTR
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fetch_en,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_target,
   fetch_unit_if.master     bus,
   output logic [XLEN-1:0]  fetch_count
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic             fetch_fault
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic            load;
   logic            advance;
   logic            handshake;

   assign load      = !if_valid || bus.if_ready;
   assign advance   = load && fetch_en;
   assign handshake = if_valid && bus.if_ready;

   pc_next_sel #(
      .TRAP_VECTOR (TRAP_VECTOR),
      .TRAP_EN     (TRAP_EN)
   ) u_pc_next_sel (
      .pc              (pc),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .advance         (advance),
      .pc_next         (pc_next)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_VECTOR;
      end else begin
         pc <= pc_next;
      end
   end

   // A redirect flushes IF/ID; a stall (valid & !ready) leaves everything untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_valid <= 1'b0;
         if_instr <= NOP_INSTR;
         if_pc    <= '0;
      end else if (redirect_valid) begin
         if_valid <= 1'b0;
         if_instr <= NOP_INSTR;
      end else if (advance) begin
         if_valid <= 1'b1;
         if_instr <= bus.imem_rdata;
         if_pc    <= pc;
      end else if (load) begin
         if_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (handshake) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   // Sticky until the next aligned redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_fault <= 1'b0;
      end else if (redirect_valid) begin
         fetch_fault <= is_misaligned(redirect_target);
      end
   end
`endif

   assign bus.imem_addr   = pc;
   assign bus.if_valid    = if_valid;
   assign bus.if_instr    = if_instr;
   assign bus.if_pc       = if_pc;
   assign bus.if_pc_plus4 = if_pc + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus queues expected words, a negedge monitor checks handshakes.
module tb_fetch_unit;
   import core_pkg::*;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] fetch_count;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_fault;
`endif

   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   fetch_unit_if bus ();

   fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fetch_en        (fetch_en),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .bus             (bus),
      .fetch_count     (fetch_count)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_fault     (fetch_fault)
`endif
   );

   always #5 clk = ~clk;

   // Zero-latency instruction memory: two real words at 0x0/0x4, a tagged pattern elsewhere.
   always_comb begin
      case (bus.imem_addr)
         32'h0000_0000: bus.imem_rdata = 32'h0050_0093;
         32'h0000_0004: bus.imem_rdata = 32'h0010_0113;
         default:       bus.imem_rdata = bus.imem_addr ^ 32'hC0DE_0000;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input logic [31:0] instr, input logic [31:0] pc);
      sb_q.push_back('{instr: instr, pc: pc});
   endtask

   task automatic check_reset_state();
      check("rst_valid", {31'd0, bus.if_valid}, 32'd0);
      check("rst_instr", bus.if_instr, 32'h0000_0013);
      check("rst_pc", bus.if_pc, 32'h0);
      check("rst_pc4", bus.if_pc_plus4, 32'h4);
      check("rst_addr", bus.imem_addr, 32'h0);
      check("rst_count", fetch_count, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("rst_fault", {31'd0, fetch_fault}, 32'd0);
`endif
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.if_valid && bus.if_ready) begin
         check("sb_avail", {31'd0, sb_q.size() > 0}, 32'd1);
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("sb_instr", bus.if_instr, mon_e.instr);
            check("sb_pc", bus.if_pc, mon_e.pc);
            check("sb_pc4", bus.if_pc_plus4, mon_e.pc + 32'd4);
         end
      end
   end

   initial begin
      rst_n           = 1'b0;
      fetch_en        = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      bus.if_ready    = 1'b0;
      #12;
      check_reset_state();

      // Streaming fetch with decode always ready.
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      fetch_en     = 1'b1;
      bus.if_ready = 1'b1;
      expect_word(32'h0050_0093, 32'h0);
      expect_word(32'h0010_0113, 32'h4);
      step(1);
      check("s1_valid", {31'd0, bus.if_valid}, 32'd1);
      check("s1_instr", bus.if_instr, 32'h0050_0093);
      check("s1_pc", bus.if_pc, 32'h0);
      check("s1_addr", bus.imem_addr, 32'h4);
      step(1);
      check("s2_instr", bus.if_instr, 32'h0010_0113);
      check("s2_pc", bus.if_pc, 32'h4);
      check("s2_count", fetch_count, 32'd1);
      step(1);
      check("s3_count", fetch_count, 32'd2);
      check("s3_pc", bus.if_pc, 32'h8);
      bus.if_ready = 1'b0;

      // Stall holding the word at 0x8, then async reset mid-cycle.
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("st8_instr", bus.if_instr, 32'hC0DE_0008);
         check("st8_pc", bus.if_pc, 32'h8);
         check("st8_addr", bus.imem_addr, 32'hC);
         check("st8_count", fetch_count, 32'd2);
      end
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_state();

      // Stall on the first valid word; address must stay at 4.
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      fetch_en     = 1'b1;
      bus.if_ready = 1'b0;
      step(1);
      check("b1_valid", {31'd0, bus.if_valid}, 32'd1);
      check("b1_instr", bus.if_instr, 32'h0050_0093);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("st0_instr", bus.if_instr, 32'h0050_0093);
         check("st0_pc", bus.if_pc, 32'h0);
         check("st0_addr", bus.imem_addr, 32'h4);
         check("st0_count", fetch_count, 32'd0);
      end
      bus.if_ready = 1'b1;
      expect_word(32'h0050_0093, 32'h0);
      step(1);
      check("res_pc", bus.if_pc, 32'h4);
      check("res_instr", bus.if_instr, 32'h0010_0113);
      check("res_count", fetch_count, 32'd1);
      bus.if_ready = 1'b0;

      // Redirect while stalled: one bubble, then the target word.
      redirect_valid  = 1'b1;
      redirect_target = 32'h40;
      step(1);
      check("rd_valid", {31'd0, bus.if_valid}, 32'd0);
      check("rd_instr", bus.if_instr, 32'h0000_0013);
      check("rd_addr", bus.imem_addr, 32'h40);
      check("rd_count", fetch_count, 32'd1);
      redirect_valid = 1'b0;
      step(1);
      check("rd2_valid", {31'd0, bus.if_valid}, 32'd1);
      check("rd2_pc", bus.if_pc, 32'h40);
      check("rd2_instr", bus.if_instr, 32'hC0DE_0040);
      check("rd2_addr", bus.imem_addr, 32'h44);

      // Redirect coinciding with a handshake, then PC wrap.
      bus.if_ready = 1'b1;
      expect_word(32'hC0DE_0040, 32'h40);
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      step(1);
      check("wr_valid", {31'd0, bus.if_valid}, 32'd0);
      check("wr_count", fetch_count, 32'd2);
      check("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
      redirect_valid = 1'b0;
      expect_word(32'h3F21_FFFC, 32'hFFFF_FFFC);
      expect_word(32'h0050_0093, 32'h0);
      step(1);
      check("wr1_pc", bus.if_pc, 32'hFFFF_FFFC);
      check("wr1_pc4", bus.if_pc_plus4, 32'h0);
      check("wr1_addr", bus.imem_addr, 32'h0);
      step(1);
      check("wr2_pc", bus.if_pc, 32'h0);
      check("wr2_count", fetch_count, 32'd3);

      // Misaligned redirect.
      redirect_valid  = 1'b1;
      redirect_target = 32'h42;
      step(1);
      check("ma_count", fetch_count, 32'd4);
      check("ma_valid", {31'd0, bus.if_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("ma_addr", bus.imem_addr, 32'h100);
      check("ma_fault", {31'd0, fetch_fault}, 32'd1);
`else
      check("ma_addr", bus.imem_addr, 32'h40);
`endif
      redirect_valid = 1'b0;
      fetch_en       = 1'b0;
      step(1);
      check("fe0_valid", {31'd0, bus.if_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("fe0_addr", bus.imem_addr, 32'h100);
      check("fe0_fault", {31'd0, fetch_fault}, 32'd1);
`else
      check("fe0_addr", bus.imem_addr, 32'h40);
`endif

      // Aligned redirect clears the fault and resumes fetching.
      redirect_valid  = 1'b1;
      redirect_target = 32'h80;
      fetch_en        = 1'b1;
      step(1);
      check("al_addr", bus.imem_addr, 32'h80);
      check("al_valid", {31'd0, bus.if_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("al_fault", {31'd0, fetch_fault}, 32'd0);
`endif
      redirect_valid = 1'b0;
      expect_word(32'hC0DE_0080, 32'h80);
      step(1);
      check("al2_pc", bus.if_pc, 32'h80);
      check("al2_valid", {31'd0, bus.if_valid}, 32'd1);
      fetch_en = 1'b0;

      // Drain with fetch disabled: register empties, PC holds.
      step(1);
      check("dr_valid", {31'd0, bus.if_valid}, 32'd0);
      check("dr_count", fetch_count, 32'd5);
      check("dr_addr", bus.imem_addr, 32'h84);
      step(1);
      check("dr2_addr", bus.imem_addr, 32'h84);
      check("dr2_count", fetch_count, 32'd5);

      check("sb_drained", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
